onehot_decoder_seq: RTL and testbench

//  Sequential binary-to-one-hot decoder, the inverse of the team's priority encoder.

---
 rtl/dec_pkg.sv | 17 +
 rtl/dec_hold_cnt.sv | 29 ++
 rtl/onehot_decoder_seq.sv | 98 +++++++++
 tb/tb_onehot_decoder_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
package dec_pkg;

  typedef enum logic {IDLE, DRIVE} dec_state_t;

  // Widest one-hot vector the helper can build; callers cast down to N.
  localparam int unsigned MAX_N = 256;

  function automatic logic [MAX_N-1:0] code_to_onehot(input int unsigned code,
                                                      input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (code < n && code < MAX_N) v = MAX_N'(1) << code;
    return v;
  endfunction

endpackage

// File: rtl/dec_hold_cnt.sv
// Loadable 0..HOLD-1 hold counter; last flags the final strobe cycle.
module dec_hold_cnt #(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_reg;

  assign last = (cnt_reg == LAST_VAL);

  // Saturates at HOLD-1 so an idle counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (load)
      cnt_reg <= '0;
    else if (en && !last)
      cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential binary-to-one-hot decoder: each accepted code drives 1<<code for HOLD cycles.
// Optional sticky illegal-code flag enabled by defining DEC_RANGE_CHK_EN.
module onehot_decoder_seq
  import dec_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int HOLD   = 1,
  localparam int CODE_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  input  logic              abort,
  output logic [N-1:0]      out_onehot,
  output logic              out_valid,
  output logic              err
);

  localparam logic [CODE_W:0] N_VAL = (CODE_W + 1)'(N);

  dec_state_t state_reg, state_next;
  logic [N-1:0] out_onehot_reg, onehot_next;
  logic         out_valid_reg, valid_next;
  logic         last;
  logic         accept;
  logic         code_legal;
  logic         load;
  logic [N-1:0] decoded;

  assign in_ready   = !abort && (state_reg == IDLE || last);
  assign accept     = in_valid && in_ready;
  assign code_legal = ({1'b0, in_code} < N_VAL);
  // Illegal codes complete the handshake but never start a strobe.
  assign load       = accept && code_legal;
  assign decoded    = N'(code_to_onehot(32'(in_code), 32'(N)));

  dec_hold_cnt #(.HOLD(HOLD)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (state_reg == DRIVE),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      out_onehot_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      out_onehot_reg <= onehot_next;
      out_valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (load) state_next = DRIVE;
      DRIVE: begin
        if (abort)
          state_next = IDLE;
        else if (last)
          state_next = load ? DRIVE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    onehot_next = '0;
    valid_next  = 1'b0;
    if (state_next == DRIVE) begin
      valid_next  = 1'b1;
      onehot_next = load ? decoded : out_onehot_reg;
    end
  end

  assign out_onehot = out_onehot_reg;
  assign out_valid  = out_valid_reg;

`ifdef DEC_RANGE_CHK_EN
  logic err_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_reg <= 1'b0;
    else if (accept && !code_legal)
      err_reg <= 1'b1;
  end
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench: N=4/HOLD=3 main instance, N=3/HOLD=3 range instance, N=4/HOLD=1 throughput instance.
module tb_onehot_decoder_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef DEC_RANGE_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // Main instance: N=4, HOLD=3
  logic       a_valid, a_ready, a_abort, a_ovalid, a_err;
  logic [1:0] a_code;
  logic [3:0] a_onehot;
  onehot_decoder_seq #(.N(4), .HOLD(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_code(a_code),
    .in_ready(a_ready), .abort(a_abort), .out_onehot(a_onehot),
    .out_valid(a_ovalid), .err(a_err)
  );

  // Range instance: N=3, HOLD=3
  logic       b_valid, b_ready, b_abort, b_ovalid, b_err;
  logic [1:0] b_code;
  logic [2:0] b_onehot;
  onehot_decoder_seq #(.N(3), .HOLD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_code(b_code),
    .in_ready(b_ready), .abort(b_abort), .out_onehot(b_onehot),
    .out_valid(b_ovalid), .err(b_err)
  );

  // Throughput instance: N=4, HOLD=1
  logic       c_valid, c_ready, c_abort, c_ovalid, c_err;
  logic [1:0] c_code;
  logic [3:0] c_onehot;
  onehot_decoder_seq #(.N(4), .HOLD(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_code(c_code),
    .in_ready(c_ready), .abort(c_abort), .out_onehot(c_onehot),
    .out_valid(c_ovalid), .err(c_err)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] oh, input logic v);
    check({tag, ".onehot"}, 32'(a_onehot), 32'(oh));
    check({tag, ".valid"},  32'(a_ovalid), 32'(v));
  endtask

  initial begin
    a_valid = 0; a_code = 0; a_abort = 0;
    b_valid = 0; b_code = 0; b_abort = 0;
    c_valid = 0; c_code = 0; c_abort = 0;
    rst_n = 0;
    step();
    check_a("reset", 4'b0000, 1'b0);
    check("reset.err", 32'(a_err), 32'(0));
    rst_n = 1;
    step();
    check("reset.ready", 32'(a_ready), 32'(1));

    // 1: single code 2, held 3 cycles
    a_valid = 1; a_code = 2'd2;
    #1 check("t1.ready_t0", 32'(a_ready), 32'(1));
    step(); a_valid = 0; #1;
    check_a("t1.c1", 4'b0100, 1'b1);
    check("t1.ready_c1", 32'(a_ready), 32'(0));
    step();
    check_a("t1.c2", 4'b0100, 1'b1);
    check("t1.ready_c2", 32'(a_ready), 32'(0));
    step();
    check_a("t1.c3", 4'b0100, 1'b1);
    check("t1.ready_c3", 32'(a_ready), 32'(1));
    step();
    check_a("t1.c4", 4'b0000, 1'b0);

    // 2: code 2 then 0 offered in the last drive cycle, no gap
    a_valid = 1; a_code = 2'd2;
    step(); a_valid = 0; a_code = 2'd3; #1;
    check_a("t2.c1", 4'b0100, 1'b1);
    step();
    check_a("t2.c2", 4'b0100, 1'b1);
    step();
    a_valid = 1; a_code = 2'd0; #1;
    check_a("t2.c3", 4'b0100, 1'b1);
    check("t2.ready_c3", 32'(a_ready), 32'(1));
    step(); a_valid = 0; a_code = 2'd3; #1;
    check_a("t2.c4", 4'b0001, 1'b1);
    step();
    check_a("t2.c5", 4'b0001, 1'b1);
    step();
    check_a("t2.c6", 4'b0001, 1'b1);
    step();
    check_a("t2.c7", 4'b0000, 1'b0);

    // 3: abort in 2nd drive cycle while offering code 3
    a_valid = 1; a_code = 2'd1;
    step(); a_valid = 0; #1;
    check_a("t3.c1", 4'b0010, 1'b1);
    step();
    a_abort = 1; a_valid = 1; a_code = 2'd3; #1;
    check("t3.ready_abort", 32'(a_ready), 32'(0));
    step(); a_abort = 0; a_valid = 0; #1;
    check_a("t3.after", 4'b0000, 1'b0);
    check("t3.ready_after", 32'(a_ready), 32'(1));
    step();
    check_a("t3.no_accept", 4'b0000, 1'b0);

    // 4: asynchronous reset mid-strobe
    a_valid = 1; a_code = 2'd3;
    step(); a_valid = 0; #1;
    check_a("t4.c1", 4'b1000, 1'b1);
    rst_n = 0; #1;
    check_a("t4.async", 4'b0000, 1'b0);
    rst_n = 1; #1;
    check("t4.ready", 32'(a_ready), 32'(1));
    step();
    check_a("t4.idle", 4'b0000, 1'b0);

    // 5: N=3, illegal code 3
    b_valid = 1; b_code = 2'd3;
    #1 check("t5.ready", 32'(b_ready), 32'(1));
    step(); b_valid = 0; #1;
    check("t5.onehot", 32'(b_onehot), 32'(0));
    check("t5.valid", 32'(b_ovalid), 32'(0));
    check("t5.err", 32'(b_err), 32'(EXP_ERR));
    check("t5.ready_after", 32'(b_ready), 32'(1));
    b_valid = 1; b_code = 2'd2;
    step(); b_valid = 0; #1;
    check("t5.legal_onehot", 32'(b_onehot), 32'(3'b100));
    check("t5.err_sticky", 32'(b_err), 32'(EXP_ERR));

    // 6: HOLD=1 full throughput
    c_valid = 1; c_code = 2'd0;
    #1 check("t6.ready0", 32'(c_ready), 32'(1));
    step(); c_code = 2'd1; #1;
    check("t6.oh0", 32'(c_onehot), 32'(4'b0001));
    check("t6.ready1", 32'(c_ready), 32'(1));
    step(); c_code = 2'd2; #1;
    check("t6.oh1", 32'(c_onehot), 32'(4'b0010));
    check("t6.ready2", 32'(c_ready), 32'(1));
    step(); c_code = 2'd3; #1;
    check("t6.oh2", 32'(c_onehot), 32'(4'b0100));
    check("t6.ready3", 32'(c_ready), 32'(1));
    step(); c_valid = 0; #1;
    check("t6.oh3", 32'(c_onehot), 32'(4'b1000));
    check("t6.valid3", 32'(c_ovalid), 32'(1));
    step();
    check("t6.idle", 32'(c_onehot), 32'(0));
    check("t6.idle_valid", 32'(c_ovalid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
